// File: rtl/way_read_sequencer.sv
// Way-data read sequencer: walks word offsets of one cache way and streams each word out with valid/ready.
// Optional statistics counters are built only when WAY_READ_SEQ_STATS_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a request; data-array port idle
// STREAM | reading one word per capture into the output register
// DRAIN  | final word captured, waiting for its handshake
module way_read_sequencer #(
    parameter int NUM_WAYS     = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [NUM_WAYS-1:0]     req_way,
    input  logic [OFFSET_WIDTH-1:0] req_offset,
    input  logic [OFFSET_WIDTH-1:0] req_len,
    input  logic                    req_wrap,
    output logic                    req_err,
    output logic [NUM_WAYS-1:0]     rd_target_way,
    output logic [OFFSET_WIDTH-1:0] rd_offset,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [OFFSET_WIDTH-1:0] out_offset,
    output logic                    out_last
`ifdef WAY_READ_SEQ_STATS_EN
    ,
    output logic [15:0]             burst_count,
    output logic [7:0]              err_count
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    localparam int CW = OFFSET_WIDTH + 1;
    localparam logic [CW-1:0] LINE_WORDS = {1'b1, {OFFSET_WIDTH{1'b0}}};
    localparam logic [CW-1:0] MAX_OFF    = {1'b0, {OFFSET_WIDTH{1'b1}}};
    localparam logic [CW-1:0] ONE_CNT    = CW'(1);

    logic [1:0]              state;
    logic [NUM_WAYS-1:0]     wayReg;
    logic [OFFSET_WIDTH-1:0] curOffset;
    logic [CW-1:0]           remCount;
    logic                    outValid;
    logic                    outLast;
    logic [DATA_WIDTH-1:0]   outData;
    logic [OFFSET_WIDTH-1:0] outOffset;
    logic                    reqErr;

    logic                    wayOneHot;
    logic [CW-1:0]           endOffset;
    logic [CW-1:0]           reqCount;
    logic                    capture;
    logic                    handshake;

    always_comb begin
        wayOneHot = (req_way != '0) && ((req_way & (req_way - NUM_WAYS'(1))) == '0);
        endOffset = {1'b0, req_offset} + {1'b0, req_len};
        // Linear bursts stop at the end of the line instead of wrapping.
        if (!req_wrap && (endOffset > MAX_OFF))
            reqCount = LINE_WORDS - {1'b0, req_offset};
        else
            reqCount = {1'b0, req_len} + ONE_CNT;
        capture   = (state == STREAM) && (!outValid || out_ready);
        handshake = outValid && out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wayReg    <= '0;
            curOffset <= '0;
            remCount  <= '0;
            outValid  <= 1'b0;
            outLast   <= 1'b0;
            outData   <= '0;
            outOffset <= '0;
            reqErr    <= 1'b0;
        end else begin
            reqErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!wayOneHot) begin
                            reqErr <= 1'b1;
                        end else begin
                            wayReg    <= req_way;
                            curOffset <= req_offset;
                            remCount  <= reqCount;
                            state     <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (capture) begin
                        outData   <= rd_data;
                        outOffset <= curOffset;
                        outValid  <= 1'b1;
                        outLast   <= (remCount == ONE_CNT);
                        curOffset <= curOffset + OFFSET_WIDTH'(1);
                        remCount  <= remCount - ONE_CNT;
                        if (remCount == ONE_CNT)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        outValid <= 1'b0;
                        outLast  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready     = (state == IDLE);
    assign req_err       = reqErr;
    assign rd_target_way = (state == STREAM) ? wayReg : '0;
    assign rd_offset     = curOffset;
    assign out_valid     = outValid;
    assign out_data      = outData;
    assign out_offset    = outOffset;
    assign out_last      = outLast;

`ifdef WAY_READ_SEQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_count <= '0;
            err_count   <= '0;
        end else begin
            if (handshake && outLast && (burst_count != 16'hFFFF))
                burst_count <= burst_count + 16'd1;
            if (reqErr && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_way_read_sequencer.sv
// Directed bench for way_read_sequencer: table of bursts plus back-pressure and mid-burst reset sequences.
module tb_way_read_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_way;
    logic [2:0]  req_offset;
    logic [2:0]  req_len;
    logic        req_wrap;
    logic        req_err;
    logic [3:0]  rd_target_way;
    logic [2:0]  rd_offset;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_offset;
    logic        out_last;
`ifdef WAY_READ_SEQ_STATS_EN
    logic [15:0] burst_count;
    logic [7:0]  err_count;
`endif

    int tests = 0;
    int fails = 0;

    way_read_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_way(req_way),
        .req_offset(req_offset), .req_len(req_len), .req_wrap(req_wrap), .req_err(req_err),
        .rd_target_way(rd_target_way), .rd_offset(rd_offset), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_offset(out_offset), .out_last(out_last)
`ifdef WAY_READ_SEQ_STATS_EN
        , .burst_count(burst_count), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    // Data-array model: word content encodes the way and offset it came from.
    function automatic logic [31:0] arrayWord(input logic [3:0] way, input logic [2:0] off);
        return (way == 4'b0) ? 32'h0 : {12'hD00, way, 8'h5A, 5'b0, off};
    endfunction

    assign rd_data = arrayWord(rd_target_way, rd_offset);

    typedef struct {
        logic [3:0] way;
        logic [2:0] off;
        logic [2:0] len;
        logic       wrap;
        logic       expErr;
        int         expN;
        logic [2:0] expLastOff;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input logic [3:0] way, input logic [2:0] firstOff, input int startIdx,
                           input int expN, input logic [2:0] expLastOff);
        int n;
        bit done;
        logic [2:0] expOff;
        n = startIdx;
        done = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            step();
            chk("stream_valid", out_valid, 1);
            if (out_valid) begin
                expOff = firstOff + 3'(n);
                chk("out_offset", out_offset, expOff);
                chk("out_data", out_data, arrayWord(way, expOff));
                chk("out_last", out_last, (n == expN - 1));
                n++;
                if (out_last) begin
                    done = 1'b1;
                    chk("last_offset", out_offset, expLastOff);
                end
            end
        end
        chk("word_count", n, expN);
        step();
        chk("req_ready_back", req_ready, 1);
        chk("valid_drop", out_valid, 0);
        chk("rd_way_idle", rd_target_way, 0);
    endtask

    task automatic runVec(input vec_t v);
        req_way = v.way; req_offset = v.off; req_len = v.len; req_wrap = v.wrap;
        req_valid = 1'b1;
        chk("req_ready_idle", req_ready, 1);
        step();
        req_valid = 1'b0;
        if (v.expErr) begin
            chk("req_err_pulse", req_err, 1);
            chk("err_no_valid", out_valid, 0);
            chk("err_stay_idle", req_ready, 1);
            chk("err_no_read", rd_target_way, 0);
            step();
            chk("req_err_clear", req_err, 0);
            chk("err_no_valid2", out_valid, 0);
        end else begin
            chk("req_err_quiet", req_err, 0);
            chk("busy", req_ready, 0);
            chk("first_no_valid", out_valid, 0);
            chk("rd_way", rd_target_way, v.way);
            chk("rd_off", rd_offset, v.off);
            collect(v.way, v.off, 0, v.expN, v.expLastOff);
        end
    endtask

    initial begin
        vecs[0] = '{4'b0010, 3'd0, 3'd3, 1'b0, 1'b0, 4, 3'd3};
        vecs[1] = '{4'b0001, 3'd6, 3'd7, 1'b1, 1'b0, 8, 3'd5};
        vecs[2] = '{4'b1000, 3'd6, 3'd3, 1'b0, 1'b0, 2, 3'd7};
        vecs[3] = '{4'b0100, 3'd5, 3'd0, 1'b0, 1'b0, 1, 3'd5};
        vecs[4] = '{4'b0001, 3'd2, 3'd7, 1'b0, 1'b0, 6, 3'd7};
        vecs[5] = '{4'b0110, 3'd1, 3'd2, 1'b0, 1'b1, 0, 3'd0};
        vecs[6] = '{4'b0000, 3'd1, 3'd2, 1'b0, 1'b1, 0, 3'd0};
        vecs[7] = '{4'b0010, 3'd7, 3'd2, 1'b1, 1'b0, 3, 3'd1};

        rst = 1'b1; req_valid = 1'b0; req_way = '0; req_offset = '0; req_len = '0;
        req_wrap = 1'b0; out_ready = 1'b1;
        step();
        step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_rd_way", rd_target_way, 0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) runVec(vecs[i]);

`ifdef WAY_READ_SEQ_STATS_EN
        chk("err_count", err_count, 2);
        chk("burst_count", burst_count, 6);
`endif

        // Back-pressure: 5 words from offset 1, stall 3 cycles while word at offset 2 is presented.
        req_way = 4'b0100; req_offset = 3'd1; req_len = 3'd4; req_wrap = 1'b0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("bp_w0_off", out_offset, 1);
        step();
        chk("bp_w1_off", out_offset, 2);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_off", out_offset, 2);
            chk("bp_hold_data", out_data, arrayWord(4'b0100, 3'd2));
            chk("bp_rd_off_stable", rd_offset, 3);
            chk("bp_rd_way_stable", rd_target_way, 4'b0100);
        end
        out_ready = 1'b1;
        collect(4'b0100, 3'd1, 2, 5, 3'd5);

        // Reset after the second word of an 8-word burst, then a fresh request.
        req_way = 4'b0001; req_offset = 3'd0; req_len = 3'd7; req_wrap = 1'b1; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("mid_w1_off", out_offset, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_off", out_offset, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_rd_way", rd_target_way, 0);
        chk("mid_rst_rd_off", rd_offset, 0);
        chk("mid_rst_err", req_err, 0);
        step();
        chk("mid_rst_held_valid", out_valid, 0);
        rst = 1'b0;
        step();
        runVec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
